// File: rtl/out_arb_pkg.sv
// out_arb_pkg: shared types and helpers for the output result arbiter.
//   clog2_min1  : pointer/index width for a channel count (never below 1 bit)
//   res_entry_t : {id, data} layout of one FIFO_OUT entry (default widths)
//   ACK_LAT     : cycles from FIFO_OUT write to the producer's written pulse
package out_arb_pkg;

  localparam int unsigned ACK_LAT = 1;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] data;
  } res_entry_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_result_arbiter_rr.sv
// rr_arbiter: purely combinational request arbiter.
//   req     in  NUM_CH  request vector
//   ptr     in  CH_W    round-robin priority pointer (lowest index searched first)
//   gnt     out NUM_CH  one-hot grant (all zero when no request)
//   gnt_idx out CH_W    binary index of the granted request
// Build option: OUT_ARB_FIXED_PRIO_EN selects fixed priority (index 0 highest)
// instead of masked-priority round-robin; ptr is then ignored.
module rr_arbiter
  import out_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [NUM_CH-1:0] sel_req;

`ifdef OUT_ARB_FIXED_PRIO_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;
  assign sel_req    = req;
`else
  // Requests at or above ptr win first; if none, the wrap-around search is
  // simply the lowest request overall.
  logic [NUM_CH-1:0] above;
  logic [NUM_CH-1:0] masked;

  always_comb begin
    above = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      above[i] = (CH_W'(i) >= ptr);
    end
  end

  assign masked  = req & above;
  assign sel_req = (|masked) ? masked : req;
`endif

  always_comb begin
    logic found;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && sel_req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/out_result_arbiter.sv
// out_result_arbiter: arbitrates NUM_CH ALU result producers onto FIFO_OUT.
//   clk, rst_n   single clock, asynchronous active-low reset
//   valid_res    per-channel result valid (held until written[i] is seen)
//   result       packed results, channel i at [i*FIFO_OUT_WIDTH +: FIFO_OUT_WIDTH]
//   ready_f_res  FIFO_OUT not full
//   fifo_res     entry to write (combinational, zero when nothing eligible)
//   w_en_out     FIFO_OUT write strobe (combinational)
//   written      registered one-hot write acknowledge
//   grant_ptr    round-robin priority pointer (debug)
// Build option: OUT_ARB_FIXED_PRIO_EN -> fixed priority, grant_ptr held at 0.
module out_result_arbiter
  import out_arb_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned ID_SIZE        = 8,
  parameter int unsigned FIFO_OUT_WIDTH = ID_SIZE + DATA_SIZE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                valid_res,
  input  logic [NUM_CH*FIFO_OUT_WIDTH-1:0] result,
  input  logic                             ready_f_res,
  output logic [FIFO_OUT_WIDTH-1:0]        fifo_res,
  output logic                             w_en_out,
  output logic [NUM_CH-1:0]                written,
  output logic [clog2_min1(NUM_CH)-1:0]    grant_ptr
);

  localparam int unsigned CH_W = clog2_min1(NUM_CH);

  if (ACK_LAT != 1) begin : g_ack_lat_chk
    $error("out_result_arbiter implements a single-cycle write acknowledge");
  end

  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] written_q, written_d;
  logic [CH_W-1:0]   grant_ptr_q, grant_ptr_d;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;

  assign eligible = valid_res & ~pend_q;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req     (eligible),
    .ptr     (grant_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign w_en_out = ready_f_res & (|eligible);

  // gnt is all-zero when nothing is eligible, so fifo_res falls back to zero.
  always_comb begin
    fifo_res = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) fifo_res = result[i*FIFO_OUT_WIDTH +: FIFO_OUT_WIDTH];
    end
  end

  // The granted channel is always valid, so its pend bit is never cleared in
  // the same cycle it is set.
  always_comb begin
    pend_d    = (pend_q & valid_res) | (w_en_out ? gnt : '0);
    written_d = w_en_out ? gnt : '0;
`ifdef OUT_ARB_FIXED_PRIO_EN
    grant_ptr_d = '0;
`else
    grant_ptr_d = grant_ptr_q;
    if (w_en_out) begin
      grant_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
`endif
  end

`ifdef OUT_ARB_FIXED_PRIO_EN
  logic idx_unused;
  assign idx_unused = ^gnt_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      written_q   <= '0;
      grant_ptr_q <= '0;
    end else begin
      pend_q      <= pend_d;
      written_q   <= written_d;
      grant_ptr_q <= grant_ptr_d;
    end
  end

  assign written   = written_q;
  assign grant_ptr = grant_ptr_q;

endmodule

// File: tb/tb_out_result_arbiter.sv
module tb_out_result_arbiter;

`ifdef OUT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [23:0] R0 = 24'h05_00AA;
  localparam logic [23:0] R1 = 24'h0A_1234;
  localparam logic [23:0] Q0 = 24'h01_0000;
  localparam logic [23:0] Q1 = 24'h02_1111;
  localparam logic [23:0] Q2 = 24'h03_2222;
  localparam logic [23:0] Q3 = 24'h04_3333;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]  valid2 = '0;
  logic [47:0] result2 = {R1, R0};
  logic        ready2 = 1'b1;
  logic [23:0] fifo2;
  logic        wen2;
  logic [1:0]  written2;
  logic [0:0]  ptr2;

  logic [3:0]  valid4 = '0;
  logic [95:0] result4 = {Q3, Q2, Q1, Q0};
  logic        ready4 = 1'b1;
  logic [23:0] fifo4;
  logic        wen4;
  logic [3:0]  written4;
  logic [1:0]  ptr4;

  int unsigned passed = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  out_result_arbiter #(.NUM_CH(2), .DATA_SIZE(16), .ID_SIZE(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_res(valid2), .result(result2),
    .ready_f_res(ready2), .fifo_res(fifo2), .w_en_out(wen2),
    .written(written2), .grant_ptr(ptr2)
  );

  out_result_arbiter #(.NUM_CH(4), .DATA_SIZE(16), .ID_SIZE(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_res(valid4), .result(result4),
    .ready_f_res(ready4), .fifo_res(fifo4), .w_en_out(wen4),
    .written(written4), .grant_ptr(ptr4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid2 = '0;
    valid4 = '0;
    ready2 = 1'b1;
    ready4 = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    valid2 = '0;
    valid4 = '0;
    #2;
    checks++; if (wen2 !== 1'b0) $display("FAIL reset_wen got %b exp 0", wen2); else passed++;
    checks++; if (fifo2 !== 24'h0) $display("FAIL reset_fifo got %h exp 000000", fifo2); else passed++;
    checks++; if (written2 !== 2'b00) $display("FAIL reset_written got %b exp 00", written2); else passed++;
    checks++; if (ptr2 !== 1'b0) $display("FAIL reset_ptr got %h exp 0", ptr2); else passed++;
    checks++; if (ptr4 !== 2'd0 || written4 !== 4'b0) $display("FAIL reset_dut4 got ptr %h wr %b exp 0 0000", ptr4, written4); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    valid2 = 2'b01;
    #1;
    checks++; if (wen2 !== 1'b1) $display("FAIL single_wen got %b exp 1", wen2); else passed++;
    checks++; if (fifo2 !== R0) $display("FAIL single_fifo got %h exp %h", fifo2, R0); else passed++;
    checks++; if (written2 !== 2'b00) $display("FAIL single_written_t got %b exp 00", written2); else passed++;
    tick();
    checks++; if (written2 !== 2'b01) $display("FAIL single_ack got %b exp 01", written2); else passed++;
    checks++; if (wen2 !== 1'b0) $display("FAIL single_no_rewrite got %b exp 0", wen2); else passed++;
    checks++; if (ptr2 !== (FIXED ? 1'b0 : 1'b1)) $display("FAIL single_ptr got %h exp %h", ptr2, FIXED ? 1'b0 : 1'b1); else passed++;
    tick();
    valid2 = 2'b00;
    #1;
    checks++; if (written2 !== 2'b00) $display("FAIL single_ack_width got %b exp 00", written2); else passed++;
    tick();
    valid2 = 2'b01;
    #1;
    checks++; if (wen2 !== 1'b1) $display("FAIL single_reissue got %b exp 1", wen2); else passed++;
    valid2 = 2'b00;
  endtask

  task automatic test_contention();
    logic [1:0]  v     [6] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00};
    logic        e_wen [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [23:0] e_fif [6] = '{R0, R1, 24'h0, R0, R1, 24'h0};
    logic [1:0]  e_wr  [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    logic [0:0]  e_ptr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      valid2 = v[k];
      #1;
      checks++; if (wen2 !== e_wen[k]) $display("FAIL cont_wen[%0d] got %b exp %b", k, wen2, e_wen[k]); else passed++;
      checks++; if (fifo2 !== e_fif[k]) $display("FAIL cont_fifo[%0d] got %h exp %h", k, fifo2, e_fif[k]); else passed++;
      checks++; if (written2 !== e_wr[k]) $display("FAIL cont_written[%0d] got %b exp %b", k, written2, e_wr[k]); else passed++;
      checks++; if (ptr2 !== (FIXED ? 1'b0 : e_ptr[k])) $display("FAIL cont_ptr[%0d] got %h exp %h", k, ptr2, FIXED ? 1'b0 : e_ptr[k]); else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready2 = 1'b0;
    valid2 = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (wen2 !== 1'b0) $display("FAIL bp_wen[%0d] got %b exp 0", k, wen2); else passed++;
      checks++; if (fifo2 !== R1) $display("FAIL bp_fifo[%0d] got %h exp %h", k, fifo2, R1); else passed++;
      checks++; if (written2 !== 2'b00 || ptr2 !== 1'b0) $display("FAIL bp_state[%0d] got wr %b ptr %h exp 00 0", k, written2, ptr2); else passed++;
      tick();
    end
    ready2 = 1'b1;
    #1;
    checks++; if (wen2 !== 1'b1 || fifo2 !== R1) $display("FAIL bp_release got wen %b fifo %h exp 1 %h", wen2, fifo2, R1); else passed++;
    tick();
    checks++; if (written2 !== 2'b10) $display("FAIL bp_ack got %b exp 10", written2); else passed++;
    checks++; if (wen2 !== 1'b0 || ptr2 !== 1'b0) $display("FAIL bp_after got wen %b ptr %h exp 0 0", wen2, ptr2); else passed++;
    valid2 = 2'b00;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    valid4 = 4'b0100;
    #1;
    checks++; if (wen4 !== 1'b1 || fifo4 !== Q2) $display("FAIL wrap_w2 got wen %b fifo %h exp 1 %h", wen4, fifo4, Q2); else passed++;
    tick();
    valid4 = 4'b0000;
    #1;
    checks++; if (written4 !== 4'b0100) $display("FAIL wrap_ack2 got %b exp 0100", written4); else passed++;
    checks++; if (ptr4 !== (FIXED ? 2'd0 : 2'd3)) $display("FAIL wrap_ptr3 got %h exp %h", ptr4, FIXED ? 2'd0 : 2'd3); else passed++;
    tick();
    valid4 = 4'b1001;
    #1;
    checks++; if (wen4 !== 1'b1 || fifo4 !== (FIXED ? Q0 : Q3)) $display("FAIL wrap_first got wen %b fifo %h exp 1 %h", wen4, fifo4, FIXED ? Q0 : Q3); else passed++;
    tick();
    checks++; if (written4 !== (FIXED ? 4'b0001 : 4'b1000)) $display("FAIL wrap_ack_first got %b exp %b", written4, FIXED ? 4'b0001 : 4'b1000); else passed++;
    checks++; if (ptr4 !== 2'd0) $display("FAIL wrap_ptr0 got %h exp 0", ptr4); else passed++;
    checks++; if (wen4 !== 1'b1 || fifo4 !== (FIXED ? Q3 : Q0)) $display("FAIL wrap_second got wen %b fifo %h exp 1 %h", wen4, fifo4, FIXED ? Q3 : Q0); else passed++;
    tick();
    valid4 = 4'b0000;
    #1;
    checks++; if (written4 !== (FIXED ? 4'b1000 : 4'b0001)) $display("FAIL wrap_ack_second got %b exp %b", written4, FIXED ? 4'b1000 : 4'b0001); else passed++;
    checks++; if (ptr4 !== (FIXED ? 2'd0 : 2'd1)) $display("FAIL wrap_ptr_end got %h exp %h", ptr4, FIXED ? 2'd0 : 2'd1); else passed++;
    tick();
  endtask

  // After a lone ch0 write the round-robin pointer favours ch1; fixed
  // priority must still pick ch0.
  task automatic test_priority();
    do_reset();
    valid2 = 2'b01;
    tick();
    valid2 = 2'b00;
    tick();
    valid2 = 2'b11;
    #1;
    checks++; if (wen2 !== 1'b1 || fifo2 !== (FIXED ? R0 : R1)) $display("FAIL prio_pick got wen %b fifo %h exp 1 %h", wen2, fifo2, FIXED ? R0 : R1); else passed++;
    tick();
    checks++; if (written2 !== (FIXED ? 2'b01 : 2'b10)) $display("FAIL prio_ack got %b exp %b", written2, FIXED ? 2'b01 : 2'b10); else passed++;
    checks++; if (fifo2 !== (FIXED ? R1 : R0)) $display("FAIL prio_next got %h exp %h", fifo2, FIXED ? R1 : R0); else passed++;
    valid2 = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid2 = 2'b01;
    tick();
    checks++; if (written2 !== 2'b01) $display("FAIL mid_pre got %b exp 01", written2); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (written2 !== 2'b00 || ptr2 !== 1'b0) $display("FAIL mid_async got wr %b ptr %h exp 00 0", written2, ptr2); else passed++;
    valid2 = 2'b00;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
